orientation_scheduler: RTL and testbench

//  Sequences the 7x7 intensity-centroid (orientation moment) datapath for ORB keypoints.

---
 rtl/orientation_scheduler.sv | 148 ++++++++++++++
 tb/tb_orientation_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/orientation_scheduler.sv
// Queues ORB keypoints, fetches 7 patch columns per keypoint, waits for the moment unit and emits {x,y,mx,my}.
// Column reads start 1 cycle after a pop. A result is held in OUT until i_kp_ready. o_req_ready is low while the queue is full.
module orientation_scheduler #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int MOM_W      = 13,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [X_W-1:0]          i_req_x,
  input  logic [Y_W-1:0]          i_req_y,
  output logic                    o_rd_en,
  output logic [X_W-1:0]          o_rd_x,
  output logic [Y_W-1:0]          o_rd_y,
  input  logic [55:0]             i_rd_data,
  output logic                    o_col_valid,
  output logic [2:0]              o_col_idx,
  output logic [55:0]             o_col_data,
  input  logic                    i_mom_valid,
  input  logic signed [MOM_W-1:0] i_mx,
  input  logic signed [MOM_W-1:0] i_my,
  output logic                    o_kp_valid,
  input  logic                    i_kp_ready,
  output logic [X_W-1:0]          o_kp_x,
  output logic [Y_W-1:0]          o_kp_y,
  output logic signed [MOM_W-1:0] o_mx,
  output logic signed [MOM_W-1:0] o_my,
  output logic                    o_drop,
  output logic                    o_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUT} state_t;

  state_t         state;
  logic [X_W-1:0] q_x [FIFO_DEPTH];
  logic [Y_W-1:0] q_y [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  logic [2:0]     col;
  logic [3:0]     wait_cnt;
  logic [X_W-1:0] kp_x;
  logic [Y_W-1:0] kp_y;
  logic           full, in_bounds, push, pop, kp_hs;

  assign full        = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign o_req_ready = !full;
  // Patch must fit entirely inside the image, so x-3 can never underflow.
  assign in_bounds   = (i_req_x >= X_W'(3)) && (i_req_x <= X_W'(WIDTH - 4)) &&
                       (i_req_y >= Y_W'(3)) && (i_req_y <= Y_W'(HEIGHT - 4));
  assign push        = i_req_valid && o_req_ready && in_bounds;
  assign kp_hs       = (state == OUT) && o_kp_valid && i_kp_ready;
  assign pop         = (count != '0) && ((state == IDLE) || kp_hs);
  assign o_col_data  = o_col_valid ? i_rd_data : 56'd0;

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_x[wr_ptr] <= i_req_x;
      q_y[wr_ptr] <= i_req_y;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      col         <= '0;
      wait_cnt    <= '0;
      kp_x        <= '0;
      kp_y        <= '0;
      o_rd_en     <= 1'b0;
      o_rd_x      <= '0;
      o_rd_y      <= '0;
      o_col_valid <= 1'b0;
      o_col_idx   <= '0;
      o_kp_valid  <= 1'b0;
      o_kp_x      <= '0;
      o_kp_y      <= '0;
      o_mx        <= '0;
      o_my        <= '0;
      o_drop      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_drop      <= i_req_valid && o_req_ready && !in_bounds;
      o_err       <= 1'b0;
      o_col_valid <= o_rd_en;
      o_col_idx   <= o_rd_en ? col : 3'd0;
      count       <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;

      // Pop serves both IDLE and OUT-handshake, so back-to-back keypoints skip IDLE.
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        kp_x    <= q_x[rd_ptr];
        kp_y    <= q_y[rd_ptr];
        o_rd_en <= 1'b1;
        col     <= 3'd0;
        o_rd_x  <= q_x[rd_ptr] - X_W'(3);
        o_rd_y  <= q_y[rd_ptr];
        state   <= FETCH;
      end

      case (state)
        IDLE: ;
        FETCH: begin
          if (col == 3'd6) begin
            o_rd_en  <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            col    <= col + 3'd1;
            o_rd_x <= o_rd_x + X_W'(1);
          end
        end
        WAIT: begin
          if (i_mom_valid) begin
            o_mx       <= i_mx;
            o_my       <= i_my;
            o_kp_x     <= kp_x;
            o_kp_y     <= kp_y;
            o_kp_valid <= 1'b1;
            state      <= OUT;
          end else if (wait_cnt == 4'(TIMEOUT)) begin
            o_err <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        OUT: begin
          if (kp_hs) begin
            o_kp_valid <= 1'b0;
            if (!pop) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_orientation_scheduler.sv
// Directed bench for orientation_scheduler with a patch-buffer model and a moment-unit model (latency L).
module tb_orientation_scheduler;
  localparam int L = 3;

  logic               i_clk, i_rst_n;
  logic               i_req_valid, o_req_ready;
  logic [9:0]         i_req_x;
  logic [8:0]         i_req_y;
  logic               o_rd_en;
  logic [9:0]         o_rd_x;
  logic [8:0]         o_rd_y;
  logic [55:0]        i_rd_data;
  logic               o_col_valid;
  logic [2:0]         o_col_idx;
  logic [55:0]        o_col_data;
  logic               i_mom_valid;
  logic signed [12:0] i_mx, i_my;
  logic               o_kp_valid, i_kp_ready;
  logic [9:0]         o_kp_x;
  logic [8:0]         o_kp_y;
  logic signed [12:0] o_mx, o_my;
  logic               o_drop, o_err;

  int checks = 0;
  int failures = 0;
  int mx_base = 0, my_base = 0, skip_ev = 0, ev_cnt = 0, delay = 0;
  bit spurious = 0;
  bit pb_en = 0;
  logic [9:0] pb_x = '0;

  orientation_scheduler dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_x(i_req_x), .i_req_y(i_req_y),
    .o_rd_en(o_rd_en), .o_rd_x(o_rd_x), .o_rd_y(o_rd_y), .i_rd_data(i_rd_data),
    .o_col_valid(o_col_valid), .o_col_idx(o_col_idx), .o_col_data(o_col_data),
    .i_mom_valid(i_mom_valid), .i_mx(i_mx), .i_my(i_my),
    .o_kp_valid(o_kp_valid), .i_kp_ready(i_kp_ready), .o_kp_x(o_kp_x), .o_kp_y(o_kp_y),
    .o_mx(o_mx), .o_my(o_my), .o_drop(o_drop), .o_err(o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Patch buffer: one-cycle read latency, every pixel of a column equals rd_x[7:0].
  initial begin
    i_rd_data = '0;
    forever begin
      @(posedge i_clk); #1;
      i_rd_data = pb_en ? {7{pb_x[7:0]}} : 56'd0;
      pb_en = o_rd_en;
      pb_x  = o_rd_x;
    end
  end

  // Moment unit: result L cycles after column 6; optional stray pulse during column 3.
  initial begin
    i_mom_valid = 1'b0; i_mx = '0; i_my = '0;
    forever begin
      @(posedge i_clk); #1;
      i_mom_valid = 1'b0;
      if (spurious && o_col_valid && o_col_idx == 3'd3) begin
        i_mom_valid = 1'b1; i_mx = 13'sd99; i_my = 13'sd99;
      end
      if (o_col_valid && o_col_idx == 3'd6) begin
        ev_cnt++;
        if (ev_cnt != skip_ev) delay = L;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          i_mom_valid = 1'b1; i_mx = 13'(mx_base); i_my = 13'(my_base);
        end
      end
    end
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk); #2;
  endtask

  task automatic push_kp(input int x, input int y);
    int n = 0;
    bit acc = 0;
    i_req_valid = 1'b1; i_req_x = 10'(x); i_req_y = 9'(y);
    while (!acc && n < 50) begin
      acc = o_req_ready;
      tick();
      n++;
    end
    i_req_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_kp(input int budget);
    for (int n = 0; n < budget && !o_kp_valid; n++) tick();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_rd_en"},   longint'(o_rd_en), 0);
    chk({tag, "_rd_x"},    longint'(o_rd_x), 0);
    chk({tag, "_rd_y"},    longint'(o_rd_y), 0);
    chk({tag, "_col_vld"}, longint'(o_col_valid), 0);
    chk({tag, "_col_idx"}, longint'(o_col_idx), 0);
    chk({tag, "_col_dat"}, longint'(o_col_data), 0);
    chk({tag, "_kp_vld"},  longint'(o_kp_valid), 0);
    chk({tag, "_kp_x"},    longint'(o_kp_x), 0);
    chk({tag, "_kp_y"},    longint'(o_kp_y), 0);
    chk({tag, "_mx"},      longint'(o_mx), 0);
    chk({tag, "_my"},      longint'(o_my), 0);
    chk({tag, "_drop"},    longint'(o_drop), 0);
    chk({tag, "_err"},     longint'(o_err), 0);
    chk({tag, "_ready"},   longint'(o_req_ready), 1);
  endtask

  initial begin
    int n, rd_cnt, kp_cnt;
    logic [7:0] b;
    logic [9:0] hx;
    int xs [5] = '{10, 20, 30, 40, 50};
    int ys [5] = '{11, 21, 31, 41, 51};

    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_x = '0; i_req_y = '0; i_kp_ready = 1'b0;
    repeat (3) tick();
    chk_cleared("reset");
    i_rst_n = 1'b1;
    tick();

    // 1: single keypoint, column sequence and result
    mx_base = -5; my_base = 12;
    push_kp(100, 50);
    for (n = 0; n < 20 && !o_rd_en; n++) tick();
    for (int c = 0; c < 7; c++) begin
      chk("t1_rd_en", longint'(o_rd_en), 1);
      chk("t1_rd_x", longint'(o_rd_x), 97 + c);
      chk("t1_rd_y", longint'(o_rd_y), 50);
      if (c > 0) begin
        b = 8'(97 + c - 1);
        chk("t1_col_vld", longint'(o_col_valid), 1);
        chk("t1_col_idx", longint'(o_col_idx), c - 1);
        chk("t1_col_dat", longint'(o_col_data), longint'({7{b}}));
      end
      tick();
    end
    chk("t1_col_vld6", longint'(o_col_valid), 1);
    chk("t1_col_idx6", longint'(o_col_idx), 6);
    chk("t1_rd_en_off", longint'(o_rd_en), 0);
    for (n = 0; n < 20 && !o_kp_valid; n++) tick();
    chk("t1_kp_latency", n, L + 1);
    chk("t1_kp_vld", longint'(o_kp_valid), 1);
    chk("t1_kp_x", longint'(o_kp_x), 100);
    chk("t1_kp_y", longint'(o_kp_y), 50);
    chk("t1_mx", longint'(o_mx), -5);
    chk("t1_my", longint'(o_my), 12);
    i_kp_ready = 1'b1;
    tick();
    chk("t1_kp_vld_off", longint'(o_kp_valid), 0);
    i_kp_ready = 1'b0;

    // 2: border keypoints are dropped
    push_kp(2, 50);   chk("t2_drop_x_lo", longint'(o_drop), 1);
    push_kp(637, 50); chk("t2_drop_x_hi", longint'(o_drop), 1);
    push_kp(10, 2);   chk("t2_drop_y_lo", longint'(o_drop), 1);
    push_kp(10, 477); chk("t2_drop_y_hi", longint'(o_drop), 1);
    tick();
    chk("t2_drop_pulse", longint'(o_drop), 0);
    rd_cnt = 0;
    repeat (20) begin
      if (o_rd_en) rd_cnt++;
      tick();
    end
    chk("t2_no_rd", rd_cnt, 0);
    chk("t2_ready", longint'(o_req_ready), 1);

    // 3: queue fill with stalled output, then in-order drain without IDLE bubbles
    mx_base = 7; my_base = -8;
    for (int k = 0; k < 5; k++) push_kp(xs[k], ys[k]);
    chk("t3_full", longint'(o_req_ready), 0);
    wait_kp(100);
    chk("t3_hold_vld0", longint'(o_kp_valid), 1);
    repeat (5) tick();
    chk("t3_hold_vld", longint'(o_kp_valid), 1);
    chk("t3_hold_x", longint'(o_kp_x), 10);
    chk("t3_hold_y", longint'(o_kp_y), 11);
    chk("t3_hold_mx", longint'(o_mx), 7);
    chk("t3_still_full", longint'(o_req_ready), 0);
    i_kp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_kp(100);
      chk("t3_vld", longint'(o_kp_valid), 1);
      chk("t3_x", longint'(o_kp_x), xs[k]);
      chk("t3_y", longint'(o_kp_y), ys[k]);
      chk("t3_my", longint'(o_my), -8);
      tick();
      chk("t3_next_fetch", longint'(o_rd_en), (k < 4) ? 1 : 0);
    end
    kp_cnt = 0;
    repeat (20) begin
      if (o_kp_valid) kp_cnt++;
      tick();
    end
    chk("t3_no_extra", kp_cnt, 0);

    // 4: moment timeout then normal processing of the next keypoint
    mx_base = 33; my_base = 44;
    skip_ev = ev_cnt + 1;
    push_kp(100, 100);
    push_kp(200, 200);
    for (n = 0; n < 60 && !(o_col_valid && o_col_idx == 3'd6); n++) tick();
    kp_cnt = 0;
    for (n = 0; n < 40 && !o_err; n++) begin
      if (o_kp_valid) kp_cnt++;
      tick();
    end
    chk("t4_err", longint'(o_err), 1);
    chk("t4_err_delay_ok", longint'(n >= 15 && n <= 17), 1);
    chk("t4_no_result", kp_cnt, 0);
    tick();
    chk("t4_err_pulse", longint'(o_err), 0);
    wait_kp(100);
    chk("t4_vld", longint'(o_kp_valid), 1);
    chk("t4_x", longint'(o_kp_x), 200);
    chk("t4_y", longint'(o_kp_y), 200);
    chk("t4_mx", longint'(o_mx), 33);
    chk("t4_my", longint'(o_my), 44);
    tick();

    // 6: stray moment pulse during FETCH is ignored
    mx_base = 21; my_base = -3; spurious = 1'b1;
    push_kp(300, 200);
    wait_kp(100);
    chk("t6_vld", longint'(o_kp_valid), 1);
    chk("t6_mx", longint'(o_mx), 21);
    chk("t6_my", longint'(o_my), -3);
    tick();
    spurious = 1'b0;

    // 5: reset during column 3 with two keypoints queued
    push_kp(50, 60);
    push_kp(70, 80);
    push_kp(90, 100);
    hx = 10'd50;
    for (n = 0; n < 50 && !(o_rd_en && o_rd_x == hx); n++) tick();
    chk("t5_at_col3", longint'(o_rd_en && o_rd_x == hx), 1);
    i_rst_n = 1'b0;
    tick();
    chk_cleared("t5");
    i_rst_n = 1'b1;
    kp_cnt = 0;
    rd_cnt = 0;
    repeat (40) begin
      if (o_kp_valid) kp_cnt++;
      if (o_rd_en) rd_cnt++;
      tick();
    end
    chk("t5_no_stale_kp", kp_cnt, 0);
    chk("t5_no_stale_rd", rd_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
